aes_sbox_arbiter: RTL
=====================

# aes_sbox_arbiter

Sequential arbiter that shares the single 32-bit, four-byte-parallel AES S-box between two requesters:

- **Key expansion** needs one 32-bit word per request.
- **Encipher round** needs one 128-bit state per request.

The block captures the request data, feeds it through the external combinational S-box one 32-bit word per cycle, registers the substituted result and returns it with a one-cycle acknowledge. It sits between the key memory, the round logic and the one aes_sbox instance.

## Interface

Parameters:

- FAIR, default 1. 1 = round-robin between requesters on contention; 0 = fixed priority, key requester always wins.

Ports:

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_req  in  1  key-expansion request, level.
- key_word  in  32  word to substitute; sampled at grant.
- key_ack  out  1  one-cycle pulse; key_result valid.
- key_result  out  32  substituted word; held until the next key transaction completes.
- blk_req  in  1  round-logic request, level.
- blk_data  in  128  state to substitute; sampled at grant.
- blk_ack  out  1  one-cycle pulse; blk_result valid.
- blk_result  out  128  substituted state; held until the next block transaction completes.
- sbox_in  out  32  drives the S-box input word.
- sbox_out  in  32  substituted word from the S-box, same cycle.
- busy  out  1  high in any state other than IDLE.

## Operation

**States:**

- IDLE: requests sampled here only.
  - key_req only → KEY.
  - blk_req only → BLK.
  - Both → arbitration winner.
  - Winner's data is captured into an internal operand register on the transition edge.
- KEY: sbox_in = captured key word; key_result <= sbox_out at cycle end; → ACK.
- BLK: 2-bit word counter cnt runs 0..3.
  - sbox_in = operand word cnt: word 0 = bits [127:96], word 3 = bits [31:0].
  - blk_result word cnt <= sbox_out.
  - At cnt = 3 → ACK and cnt <= 0.
- ACK: key_ack or blk_ack = 1 for the owner of the transaction; → IDLE unconditionally.

**Arbitration:**

- FAIR=1: on contention, grant the requester not granted by the previous contended grant. last_grant resets to "block", so the key requester wins the first contention.
- FAIR=0: key always wins.
- Uncontended grants do not update last_grant.

**Handshake rules:**

- Requester drops req in the cycle after it sees ack. A req still high in IDLE after ACK is a new transaction.
- Data needs to be stable only in the IDLE cycle in which the grant is made; later changes are ignored.
- Dropping req mid-transaction has no effect: the transaction completes and ack is still pulsed.
- A non-owner's result register never changes.

**Outputs and reset:**

- sbox_in = 0 in IDLE and ACK.
- busy = 0 only in IDLE.
- Reset (asynchronous, any state, including mid-BLK):
  - state = IDLE, cnt = 0, last_grant = block, operand = 0.
  - key_ack = blk_ack = 0, busy = 0.
  - key_result = 0, blk_result = 0.
  - sbox_in = 0.
- After reset deassertion, a pending req is serviced from IDLE normally; an interrupted transaction is never acked.

## Timing

- Key latency:
  - key_req high in IDLE, cycle 0.
  - KEY, cycle 1.
  - key_ack = 1, cycle 2.
  - IDLE, cycle 3.
- Block latency:
  - blk_req high in IDLE, cycle 0.
  - BLK, cycles 1–4.
  - blk_ack = 1, cycle 5.
  - IDLE, cycle 6.
- Throughput with req held continuously: one key word per 3 cycles; one block per 6 cycles.
- key_ack, blk_ack and busy are registered (state-decoded, glitch-free). sbox_in is decoded from state and counter.
- Combinational path: sbox_in → external S-box → sbox_out → result register, within one cycle.

## Test plan

- **Key single word:** key_word 0x00010203 → key_ack in cycle 2, key_result 0x637c777b; blk_result unchanged (0).
- **Block:** blk_data 0x00112233_445566778_899aabb_ccddeeff → blk_ack in cycle 5, blk_result 0x638293c3_1bfc33f5_c4eeacea_4bc12816; sbox_in sequence 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff in cycles 1–4.
- **Contention, FAIR=1:** both req held, key_word 0x52535253, blk_data all 0x00.
  - Grant order is key, block, key, block.
  - key_result = 0x00ed00ed; blk_result = 0x6363…63.
  - With FAIR=0, key is granted every time.
- **Data change after grant:** blk_data changes to all 0xff in cycle 2 → blk_result still from the captured data; key_word change after grant is likewise ignored.
- **Reset mid-block:** assert reset in cycle 3 of BLK →
  - All outputs 0 immediately; state IDLE.
  - No blk_ack.
  - Reissued request completes with the correct result 6 cycles later.
- **Back-to-back:** key_req held high across key_ack → second transaction starts in the following IDLE, key_ack pulses at cycles 2 and 5, with no double ack.

Source files
------------

// File: rtl/aes_sbox_arbiter.sv
// Time-shares one 32-bit AES S-box between key expansion (1 word) and the round logic (4 words).
// States: IDLE wait for a request | KEY one key word | BLK four block words | ACK pulse the owner's ack
module aes_sbox_arbiter #(
  parameter int FAIR = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_req,
  input  logic [31:0]  key_word,
  output logic         key_ack,
  output logic [31:0]  key_result,
  input  logic         blk_req,
  input  logic [127:0] blk_data,
  output logic         blk_ack,
  output logic [127:0] blk_result,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEY  = 2'd1;
  localparam logic [1:0] S_BLK  = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  localparam bit FAIR_EN = (FAIR != 0);

  logic [1:0]   r_state;
  logic [1:0]   r_cnt;
  logic         r_last_blk;
  logic [127:0] r_operand;
  logic [95:0]  r_blk_stage;
  logic [31:0]  r_key_result;
  logic [127:0] r_blk_result;
  logic         r_key_ack;
  logic         r_blk_ack;
  logic         r_busy;

  logic         w_contend;
  logic         w_any;
  logic         w_grant_blk;
  logic [31:0]  w_sbox_in;

  assign w_contend = key_req & blk_req;
  assign w_any     = key_req | blk_req;

  // On contention the fair arbiter alternates; otherwise the key side wins ties.
  assign w_grant_blk = w_contend ? (FAIR_EN ? ~r_last_blk : 1'b0) : blk_req;

  always_comb begin
    w_sbox_in = '0;
    case (r_state)
      S_KEY: w_sbox_in = r_operand[31:0];
      S_BLK: begin
        case (r_cnt)
          2'd0:    w_sbox_in = r_operand[127:96];
          2'd1:    w_sbox_in = r_operand[95:64];
          2'd2:    w_sbox_in = r_operand[63:32];
          default: w_sbox_in = r_operand[31:0];
        endcase
      end
      default: w_sbox_in = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_last_blk   <= 1'b1;
      r_operand    <= '0;
      r_blk_stage  <= '0;
      r_key_result <= '0;
      r_blk_result <= '0;
      r_key_ack    <= 1'b0;
      r_blk_ack    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_key_ack <= 1'b0;
      r_blk_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_busy <= 1'b1;
            if (w_contend) begin
              r_last_blk <= w_grant_blk;
            end
            if (w_grant_blk) begin
              r_operand <= blk_data;
              r_state   <= S_BLK;
            end else begin
              r_operand <= {96'd0, key_word};
              r_state   <= S_KEY;
            end
          end
        end
        S_KEY: begin
          r_key_result <= sbox_out;
          r_key_ack    <= 1'b1;
          r_state      <= S_ACK;
        end
        S_BLK: begin
          // Words are staged so blk_result only changes when the whole state is done.
          case (r_cnt)
            2'd0: r_blk_stage[95:64] <= sbox_out;
            2'd1: r_blk_stage[63:32] <= sbox_out;
            2'd2: r_blk_stage[31:0]  <= sbox_out;
            default: begin
              r_blk_result <= {r_blk_stage, sbox_out};
              r_blk_ack    <= 1'b1;
              r_state      <= S_ACK;
            end
          endcase
          if (r_cnt == 2'd3) begin
            r_cnt <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign key_ack    = r_key_ack;
  assign blk_ack    = r_blk_ack;
  assign busy       = r_busy;
  assign key_result = r_key_result;
  assign blk_result = r_blk_result;
  assign sbox_in    = w_sbox_in;

endmodule
